// File: rtl/sdram_rr_arbiter_if.sv
// Requester-side and controller-side signal bundle for sdram_rr_arbiter.
// The slave modport is the arbiter's view; master is the environment's view
// (the two requesters plus the SDRAM controller user port).
interface sdram_rr_arbiter_if;
    // Port 0: instruction / prefetch master
    logic        p0_valid;
    logic        p0_ready;
    logic        p0_rw;
    logic [22:0] p0_addr;
    logic [31:0] p0_wdata;
    logic        p0_rsp_valid;
    logic [31:0] p0_rsp_rdata;

    // Port 1: data master
    logic        p1_valid;
    logic        p1_ready;
    logic        p1_rw;
    logic [22:0] p1_addr;
    logic [31:0] p1_wdata;
    logic        p1_rsp_valid;
    logic [31:0] p1_rsp_rdata;

    // SDRAM controller user port
    logic [22:0] sd_user_addr;
    logic        sd_rw;
    logic [31:0] sd_data_in;
    logic        sd_in_valid;
    logic        sd_busy;
    logic        sd_out_valid;
    logic [31:0] sd_data_out;

    modport slave (
        input  p0_valid, p0_rw, p0_addr, p0_wdata,
        output p0_ready, p0_rsp_valid, p0_rsp_rdata,
        input  p1_valid, p1_rw, p1_addr, p1_wdata,
        output p1_ready, p1_rsp_valid, p1_rsp_rdata,
        output sd_user_addr, sd_rw, sd_data_in, sd_in_valid,
        input  sd_busy, sd_out_valid, sd_data_out
    );

    modport master (
        output p0_valid, p0_rw, p0_addr, p0_wdata,
        input  p0_ready, p0_rsp_valid, p0_rsp_rdata,
        output p1_valid, p1_rw, p1_addr, p1_wdata,
        input  p1_ready, p1_rsp_valid, p1_rsp_rdata,
        input  sd_user_addr, sd_rw, sd_data_in, sd_in_valid,
        output sd_busy, sd_out_valid, sd_data_out
    );
endinterface

// File: rtl/sdram_rr_arbiter.sv
// Two-port arbiter in front of the SDRAM controller user port.
// One request is issued per cycle at most; reads push the issuing port id
// into an in-order tag FIFO so each controller read strobe is routed back
// to its owner one cycle later. Writes complete on acceptance.
module sdram_rr_arbiter #(
    parameter int RD_DEPTH   = 4,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    sdram_rr_arbiter_if.slave         bus,
    output logic [$clog2(RD_DEPTH):0] rd_outstanding,
    output logic                      spurious_err
);
    localparam int             PTR_W      = $clog2(RD_DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(RD_DEPTH);

    logic [RD_DEPTH-1:0] tag_mem;      // one bit per entry: owning port id
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W:0]      count;

    logic en;           // first cycle after reset release is a dead cycle
    logic last_grant;   // port that won the most recent issue

    logic fifo_full;
    logic fifo_empty;
    logic elig0;
    logic elig1;
    logic issue;
    logic grant;        // 0 = port 0, 1 = port 1
    logic sel_rw;
    logic push;
    logic pop;
    logic head;

    assign fifo_full      = (count == FULL_COUNT);
    assign fifo_empty     = (count == '0);
    assign rd_outstanding = count;

    // A read can only be issued while there is room to remember its owner.
    assign elig0 = bus.p0_valid && (bus.p0_rw || !fifo_full);
    assign elig1 = bus.p1_valid && (bus.p1_rw || !fifo_full);
    assign issue = en && !bus.sd_busy && (elig0 || elig1);

    assign sel_rw = grant ? bus.p1_rw : bus.p0_rw;
    assign push   = issue && !sel_rw;
    assign pop    = bus.sd_out_valid && !fifo_empty;
    assign head   = tag_mem[rd_ptr];

    // Grant selection; a blocked read is never eligible so it cannot take the turn.
    always_comb begin
        grant = 1'b0;
        if (FIXED_PRIO) begin
            grant = !elig0;
        end else if (elig0 && elig1) begin
            grant = !last_grant;
        end else begin
            grant = elig1;
        end
    end

    // Controller request mux; idles on the port-0 values when nothing issues.
    always_comb begin
        bus.sd_in_valid  = issue;
        bus.p0_ready     = issue && !grant;
        bus.p1_ready     = issue && grant;
        bus.sd_user_addr = bus.p0_addr;
        bus.sd_rw        = bus.p0_rw;
        bus.sd_data_in   = bus.p0_wdata;
        if (issue && grant) begin
            bus.sd_user_addr = bus.p1_addr;
            bus.sd_rw        = bus.p1_rw;
            bus.sd_data_in   = bus.p1_wdata;
        end
    end

    // Arbitration state: enable after reset, remember last winner, flag stray strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en           <= 1'b0;
            last_grant   <= 1'b1;
            spurious_err <= 1'b0;
        end else begin
            en <= 1'b1;
            if (issue) begin
                last_grant <= grant;
            end
            if (bus.sd_out_valid && fifo_empty) begin
                spurious_err <= 1'b1;
            end
        end
    end

    // Tag FIFO pointers and occupancy; pointers wrap naturally at RD_DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Tag storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr] <= grant;
        end
    end

    // Response routing: register the read data toward the head-of-FIFO owner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.p0_rsp_valid <= 1'b0;
            bus.p1_rsp_valid <= 1'b0;
            bus.p0_rsp_rdata <= '0;
            bus.p1_rsp_rdata <= '0;
        end else begin
            bus.p0_rsp_valid <= pop && !head;
            bus.p1_rsp_valid <= pop && head;
            if (pop && !head) begin
                bus.p0_rsp_rdata <= bus.sd_data_out;
            end
            if (pop && head) begin
                bus.p1_rsp_rdata <= bus.sd_data_out;
            end
        end
    end
endmodule

// File: doc/sdram_rr_arbiter.md
Name: sdram_rr_arbiter

Overview:
- Shares the single SDRAM controller user port (user_addr/rw/data_in/in_valid/busy/out_valid/data_out) between two requesters: port 0 (instruction/prefetch master) and port 1 (data master).
- Arbitrates per request and tracks issued reads in an in-order tag FIFO, so each read response returns to the port that issued it.
- Sits between the bus-side adapters and sdram_controller in the user project.

Parameters:
- RD_DEPTH, 4, max outstanding reads tracked by the tag FIFO (power of 2, ≥2).
- FIXED_PRIO, 0, 0 = round-robin; 1 = port 0 always wins.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- p0_valid / p1_valid  in  1  request pending
- p0_ready / p1_ready  out  1  request accepted this cycle
- p0_rw / p1_rw  in  1  1 = write, 0 = read
- p0_addr / p1_addr  in  23  word address
- p0_wdata / p1_wdata  in  32  write data
- p0_rsp_valid / p1_rsp_valid  out  1  read data valid, one-cycle pulse
- p0_rsp_rdata / p1_rsp_rdata  out  32  read data
- sd_user_addr  out  23  to controller user_addr
- sd_rw  out  1  to controller rw
- sd_data_in  out  32  to controller data_in
- sd_in_valid  out  1  to controller in_valid
- sd_busy  in  1  controller busy
- sd_out_valid  in  1  controller read-data strobe
- sd_data_out  in  32  controller read data
- rd_outstanding  out  log2(RD_DEPTH)+1  current tag FIFO occupancy
- spurious_err  out  1  sticky: sd_out_valid seen with the tag FIFO empty

Behaviour:
- **Reset** (rst_n low, async): tag FIFO empty, last_grant = 1 (port 0 wins first), en = 0, all rsp_valid = 0, rsp_rdata = 0, spurious_err = 0.
  - en is set on the first clk after reset release, so sd_in_valid and both px_ready are 0 during reset and for that first cycle.
- **Eligibility:** port x is eligible when px_valid, and either px_rw = 1 or the tag FIFO is not full.
- **Issue condition:** en, !sd_busy, and at least one eligible port.
- **Grant** (combinational):
  - FIXED_PRIO = 1: port 0 wins if eligible, else port 1.
  - FIXED_PRIO = 0: if both are eligible, grant the port ≠ last_grant; otherwise grant the single eligible port.
- **Issue cycle:**
  - sd_in_valid = 1; sd_user_addr/sd_rw/sd_data_in are muxed from the granted port; p_grant_ready = 1 and the other ready = 0.
  - last_grant updates at the clock edge.
  - For a read, the port id is pushed into the tag FIFO at the same edge.
- **Non-issue cycle:** sd_in_valid = 0, both ready = 0; sd_* data outputs hold the port-0 mux value (don't-care).
- **Back-to-back:** max one issue per cycle. The controller raises busy the cycle after accept, so no extra blocking is needed.
- **Ordering:** controller completes reads in order, so the FIFO head always identifies the owner of the next sd_out_valid.
- **Writes:** fire-and-forget; px_ready is the completion and no response is generated.
- **Response:** on sd_out_valid with the FIFO non-empty, pop the head and register it. Next cycle: p{head}_rsp_valid = 1 and p{head}_rsp_rdata = sd_data_out (1-cycle latency). The other port's rsp_valid = 0. rsp_rdata holds its value between pulses.
- **Spurious response:** sd_out_valid with the FIFO empty means no pop, no rsp_valid, and spurious_err is set until reset.
- **Simultaneous push and pop:** both happen; occupancy is unchanged; the pointers wrap modulo RD_DEPTH.
- **FIFO full:**
  - Reads are held off (ready = 0) until a pop.
  - A pending write from either port may still issue.
  - Under round-robin, a blocked read does not consume the turn.
- **Fairness:** a port's request must not change while valid && !ready. Violating this is a requester protocol error and is not checked.
- **Reset mid-operation:** outstanding tags are discarded. Any later sd_out_valid from the in-flight controller is treated as spurious, so the controller must be reset together with this block.

Test Plan:
1. **Single read.** After reset, p0 reads addr 0x000104; controller returns 0xDEADBEEF → sd_in_valid pulse carries user_addr 0x000104 and rw 0; the cycle after sd_out_valid, p0_rsp_valid = 1 with 0xDEADBEEF, and p1_rsp_valid stays 0.
2. **Round-robin contention.** p0 and p1 both hold reads continuously → issues alternate 0,1,0,1 starting with p0; responses are routed in the same order and rd_outstanding never exceeds RD_DEPTH.
3. **FIFO full with a pending write.** Model stalls sd_out_valid until 4 reads are outstanding → further reads get ready = 0; a p1 write (addr 0x000200, data 0x12345678) still issues; one sd_out_valid lets exactly one more read issue.
4. **Push and pop in the same cycle.** A read issue coincides with sd_out_valid → rd_outstanding is unchanged and the correct port gets the response.
5. **Spurious response.** sd_out_valid with the FIFO empty → no rsp_valid on either port; spurious_err = 1 and stays set until rst_n is asserted.
6. **Reset mid-operation.** Assert rst_n low with 2 reads outstanding → all outputs go to reset values immediately (async); sd_in_valid = 0 in the first cycle after release; spurious_err = 0.
